// File: rtl/dff_stim_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dff_stim_sched
// Description : Round-robin scheduler sharing the single din/dout port of a
//               dff DUT among NREQ stimulus drivers. A granted requester
//               streams 1-bit beats into a registered din; dout is sampled
//               LAT+1 edges after each accepted beat and returned as a
//               response tagged with the requester id.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_stim_sched #(
    parameter int NREQ   = 4,   // number of requesters (2..8)
    parameter int LAT    = 1,   // DUT latency, din change to dout valid (1..4)
    parameter int MAXLEN = 8,   // beats per grant before a forced end (1..255)
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_din,
    input  logic [NREQ-1:0] req_last,
    output logic [NREQ-1:0] req_ready,
    output logic            din,
    input  logic            dout,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_dout,
    output logic            busy,
    output logic            burst_trunc
);

    // Beat counter is 8 bits wide; the MAXLEN limit is compared at that width.
    localparam logic [7:0]     MAXLEN_C  = 8'(MAXLEN);
    localparam logic [IDW-1:0] PTR_RST_C = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [IDW-1:0] gnt_q,   gnt_d;     // requester holding the port
    logic [IDW-1:0] ptr_q,   ptr_d;     // last granted id, search starts above
    logic [7:0]     cnt_q,   cnt_d;     // beats accepted in current burst
    logic           din_q,   din_d;
    logic           trunc_q, trunc_d;

    // Tag pipe: stage 0 is loaded on the accept edge, stage LAT holds the tag
    // on the edge at which the matching dout becomes valid.
    logic [LAT:0]   pv_q;
    logic [IDW-1:0] pid_q [0:LAT];

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_dout_q;

    logic           w_pick_valid;
    logic [IDW-1:0] w_pick_id;
    logic           w_accept;

    // ------------------------------------------------------------------------
    // Round-robin pick: first valid requester searching upward from ptr+1.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_id    = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_pick_valid && req_valid[idx[IDW-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = idx[IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: grant in IDLE, stream beats in BURST.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        trunc_d  = 1'b0;
        w_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    gnt_d   = w_pick_id;
                    ptr_d   = w_pick_id;
                    cnt_d   = 8'd0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // Grant is sticky: without a valid beat we simply wait,
                // holding din, for as long as it takes.
                if (req_valid[gnt_q]) begin
                    w_accept = 1'b1;
                    din_d    = req_din[gnt_q];
                    cnt_d    = cnt_q + 8'd1;
                    if (req_last[gnt_q]) begin
                        state_d = ST_IDLE;
                    end else if ((cnt_q + 8'd1) == MAXLEN_C) begin
                        state_d = ST_IDLE;
                        trunc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and data registers of the scheduler.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST_C;
            cnt_q   <= 8'd0;
            din_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            trunc_q <= trunc_d;
        end
    end

    // Tag pipe tracking accepted beats until their dout is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                pid_q[k] <= '0;
            end
        end else begin
            pv_q[0]  <= w_accept;
            pid_q[0] <= gnt_q;
            for (int k = 1; k <= LAT; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pid_q[k] <= pid_q[k-1];
            end
        end
    end

    // Response register: capture dout alongside the tag leaving the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_dout_q  <= 1'b0;
        end else begin
            rsp_valid_q <= pv_q[LAT];
            if (pv_q[LAT]) begin
                rsp_id_q   <= pid_q[LAT];
                rsp_dout_q <= dout;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ready decode from registered state only; nothing is ready in IDLE,
    // which leaves one arbitration cycle between bursts.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_ready
            assign req_ready[g] = (state_q == ST_BURST) && (gnt_q == IDW'(g));
        end
    endgenerate

    assign din         = din_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_dout    = rsp_dout_q;
    assign burst_trunc = trunc_q;
    assign busy        = (state_q != ST_IDLE) || (|pv_q);

endmodule
`default_nettype wire

// File: tb/tb_dff_stim_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dff_stim_sched
// Description : Self-checking bench for dff_stim_sched. Three schedulers with
//               LAT=1,2,3 share one stimulus; each drives its own dff latency
//               model. Expected responses are queued per instance as beats
//               are accepted and checked as responses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_stim_sched;

    localparam int NINST = 3;

    typedef struct {
        logic [1:0] id;
        logic       d;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_din;
    logic [3:0] req_last;

    logic [3:0] rdy [NINST];
    logic       dn  [NINST];
    logic       rv  [NINST];
    logic [1:0] rid [NINST];
    logic       rd  [NINST];
    logic       bsy [NINST];
    logic       trc [NINST];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sbq [NINST][$];

    always #5 clk = ~clk;

    // Cycle count used to time responses.
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NINST; g++) begin : g_inst
            // dff model: dout follows din after g+1 edges
            logic [2:0] dsr = 3'b000;
            logic       dout_m;
            always @(posedge clk) dsr <= {dsr[1:0], dn[g]};
            assign dout_m = dsr[g];

            dff_stim_sched #(.NREQ(4), .LAT(g + 1), .MAXLEN(8)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .req_valid   (req_valid),
                .req_din     (req_din),
                .req_last    (req_last),
                .req_ready   (rdy[g]),
                .din         (dn[g]),
                .dout        (dout_m),
                .rsp_valid   (rv[g]),
                .rsp_id      (rid[g]),
                .rsp_dout    (rd[g]),
                .busy        (bsy[g]),
                .burst_trunc (trc[g])
            );
        end
    endgenerate

    // Queue expected response: accept on next edge c+1, response visible c+LAT+2
    task automatic push_exp(input logic [1:0] id, input logic d);
        for (int k = 0; k < NINST; k++) begin
            exp_t e;
            e.id  = id;
            e.d   = d;
            e.due = cyc + k + 3;
            sbq[k].push_back(e);
        end
    endtask

    task automatic flush_sb();
        for (int k = 0; k < NINST; k++) sbq[k].delete();
    endtask

    task automatic sb_step();
        for (int k = 0; k < NINST; k++) begin
            while (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL sb_missing inst=%0d got=none exp id=%0d dout=%0b due=%0d now=%0d",
                         k, sbq[k][0].id, sbq[k][0].d, sbq[k][0].due, cyc);
                void'(sbq[k].pop_front());
            end
            if (rv[k] === 1'b1) begin
                checks++;
                if (sbq[k].size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected inst=%0d got id=%0d dout=%0b exp=no response cyc=%0d",
                             k, rid[k], rd[k], cyc);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    if (rid[k] !== e.id || rd[k] !== e.d || cyc != e.due) begin
                        failures++;
                        $display("FAIL sb_rsp inst=%0d got id=%0d dout=%0b cyc=%0d exp id=%0d dout=%0b cyc=%0d",
                                 k, rid[k], rd[k], cyc, e.id, e.d, e.due);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_din   = '0;
        req_last  = '0;
        flush_sb();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one beat and wait for acceptance; waits = idle negedges seen
    task automatic send_beat(input logic [1:0] id, input logic d, input logic last,
                             output int waits);
        req_valid[id] = 1'b1;
        req_din[id]   = d;
        req_last[id]  = last;
        waits = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rdy[0][id] === 1'b1) break;
            waits++;
        end
        if (waits >= 30) waits = -1;
        else push_exp(id, d);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if ({rdy[k], dn[k], rv[k], rid[k], rd[k], trc[k], bsy[k]} !== 11'b0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%b exp=%b", k,
                         {rdy[k], dn[k], rv[k], rid[k], rd[k], trc[k], bsy[k]}, 11'b0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] !== 4'b0000) begin
                failures++;
                $display("FAIL idle_ready cycle=%0d got=%b exp=0000", i, rdy[0]);
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] dat = 3'b101;
        int         w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_beat(2'd2, dat[i], (i == 2), w);
            checks++;
            if (w != ((i == 0) ? 1 : 0)) begin
                failures++;
                $display("FAIL single_wait beat=%0d got=%0d exp=%0d", i, w, (i == 0) ? 1 : 0);
            end
            checks++;
            if (dn[0] !== dat[i]) begin
                failures++;
                $display("FAIL single_din beat=%0d got=%b exp=%b", i, dn[0], dat[i]);
            end
        end
        checks++;
        if (rdy[0] !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle_ready got=%b exp=0000", rdy[0]);
        end
        drain(7);
        checks++;
        if (bsy[2] !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b exp=0", bsy[2]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy [10];
        exp_rdy = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                    4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        req_valid = 4'b1111;
        req_din   = 4'b1010;
        req_last  = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] !== exp_rdy[i]) begin
                failures++;
                $display("FAIL rr_ready step=%0d got=%b exp=%b", i, rdy[0], exp_rdy[i]);
            end
            for (int j = 0; j < 4; j++) begin
                if (exp_rdy[i][j]) push_exp(2'(j), req_din[j]);
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        drain(7);
    endtask

    task automatic test_maxlen_trunc();
        logic [9:0] pat = 10'b1101001011;
        int         w;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_beat(2'd1, pat[i], 1'b0, w);
            checks++;
            if (w != ((i == 0 || i == 8) ? 1 : 0)) begin
                failures++;
                $display("FAIL trunc_wait beat=%0d got=%0d exp=%0d", i, w,
                         (i == 0 || i == 8) ? 1 : 0);
            end
            checks++;
            if (trc[0] !== (i == 7)) begin
                failures++;
                $display("FAIL trunc_pulse beat=%0d got=%b exp=%b", i, trc[0], (i == 7));
            end
            if (i == 7) begin
                checks++;
                if (rdy[0] !== 4'b0000) begin
                    failures++;
                    $display("FAIL trunc_idle got=%b exp=0000", rdy[0]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (rdy[0] !== 4'b0010 || dn[0] !== pat[9]) begin
            failures++;
            $display("FAIL trunc_sticky got ready=%b din=%b exp ready=0010 din=%b",
                     rdy[0], dn[0], pat[9]);
        end
        drain(6);
    endtask

    task automatic test_reset_inflight();
        int w;
        do_reset();
        send_beat(2'd3, 1'b1, 1'b1, w);
        checks++;
        if (w != 1 || dn[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got wait=%0d din=%b exp wait=1 din=1", w, dn[1]);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (dn[1] !== 1'b0 || rdy[1] !== 4'b0000 || bsy[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_state got din=%b ready=%b busy=%b exp 0 0000 0",
                     dn[1], rdy[1], bsy[1]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (rv[1] !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_rsp cycle=%0d got=%b exp=0", i, rv[1]);
            end
        end
    endtask

    task automatic test_gap();
        int w;
        do_reset();
        send_beat(2'd0, 1'b1, 1'b0, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL gap_wait0 got=%0d exp=1", w);
        end
        send_beat(2'd0, 1'b0, 1'b0, w);
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL gap_wait1 got=%0d exp=0", w);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rdy[2] !== 4'b0001 || dn[2] !== 1'b0 || bsy[2] !== 1'b1) begin
                failures++;
                $display("FAIL gap_hold cycle=%0d got ready=%b din=%b busy=%b exp 0001 0 1",
                         i, rdy[2], dn[2], bsy[2]);
            end
        end
        @(posedge clk);
        #1;
        send_beat(2'd0, 1'b1, 1'b1, w);
        checks++;
        if (w != 0 || dn[2] !== 1'b1) begin
            failures++;
            $display("FAIL gap_last got wait=%0d din=%b exp wait=0 din=1", w, dn[2]);
        end
        drain(8);
        checks++;
        if (bsy[2] !== 1'b0) begin
            failures++;
            $display("FAIL gap_busy got=%b exp=0", bsy[2]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_din   = '0;
        req_last  = '0;
        fork
            forever begin
                @(negedge clk);
                sb_step();
            end
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_maxlen_trunc();
        test_reset_inflight();
        test_gap();
        drain(4);
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                failures++;
                $display("FAIL sb_leftover inst=%0d got=%0d exp=0", k, sbq[k].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
